// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with almost-full flag and optional sticky
// overflow/underflow detection, enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_LG2    = 4,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  A_full_o,
  output logic                  full_o,
  input  logic                  write_en_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic                  empty_o,
  input  logic                  read_en_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic [DEPTH_LG2:0]    count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LG2;
  localparam int unsigned CntW  = DEPTH_LG2 + 1;

  typedef logic [DEPTH_LG2-1:0] ptr_t;
  typedef logic [CntW-1:0]      cnt_t;

  localparam cnt_t CntFull  = cnt_t'(DEPTH);
  localparam cnt_t CntAfull = cnt_t'(DEPTH - AFULL_MARGIN);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  ptr_t                  wptr_q, wptr_d;
  ptr_t                  rptr_q, rptr_d;
  cnt_t                  count_q, count_d;
  logic                  push, pop;

  // Flags decode only registered state, so they never glitch on input activity.
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CntFull);
  assign A_full_o = (count_q >= CntAfull);
  assign count_o  = count_q;

  // A push while full is accepted only when the head is popped on the same edge.
  assign push = write_en_i & (~full_o | read_en_i);
  assign pop  = read_en_i & ~empty_o;

  assign read_data_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + ptr_t'(1);
    if (pop)  rptr_d = rptr_q + ptr_t'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wptr_q] <= write_data_i;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (write_en_i & full_o & ~read_en_i);
    underflow_d = underflow_q | (read_en_i & empty_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed + random bench for sync_fifo, checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned DW     = 32;
  localparam int unsigned LG2    = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MARGIN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en, read_en;
  logic [DW-1:0] write_data;
  logic          a_full, full, empty, overflow, underflow;
  logic [DW-1:0] read_data;
  logic [LG2:0]  count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q [$];
  bit            m_ovf, m_unf;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  sync_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH_LG2   (LG2),
    .AFULL_MARGIN(MARGIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .A_full_o    (a_full),
    .full_o      (full),
    .write_en_i  (write_en),
    .write_data_i(write_data),
    .empty_o     (empty),
    .read_en_i   (read_en),
    .read_data_o (read_data),
    .count_o     (count),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int unsigned n = model_q.size();
    chk({tag, ".count"}, DW'(count), DW'(n));
    chk({tag, ".empty"}, DW'(empty), DW'(n == 0));
    chk({tag, ".full"}, DW'(full), DW'(n == DEPTH));
    chk({tag, ".afull"}, DW'(a_full), DW'(n >= DEPTH - MARGIN));
    chk({tag, ".rdata"}, read_data, (n == 0) ? '0 : model_q[0]);
    chk({tag, ".ovf"}, DW'(overflow), DW'(ErrEn && m_ovf));
    chk({tag, ".unf"}, DW'(underflow), DW'(ErrEn && m_unf));
  endtask

  // One clock: drive inputs, advance the model from pre-edge occupancy, sample 1 after edge.
  task automatic step(input string tag, input bit r, input bit we, input logic [DW-1:0] wd,
                      input bit re);
    int unsigned n = model_q.size();
    bit          do_pop  = re && (n > 0);
    bit          do_push = we && ((n < DEPTH) || re);
    rst = r; write_en = we; write_data = wd; read_en = re;
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (we && n == DEPTH && !re) m_ovf = 1'b1;
      if (re && n == 0) m_unf = 1'b1;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
    end
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; write_data = '0;
    m_ovf = 1'b0; m_unf = 1'b0;

    step("reset", 1'b1, 1'b0, '0, 1'b0);
    step("idle", 1'b0, 1'b0, '0, 1'b0);
    chk("idle.rdata0", read_data, '0);

    step("pushA5", 1'b0, 1'b1, 32'hA5, 1'b0);
    chk("pushA5.head", read_data, 32'hA5);
    chk("pushA5.cnt1", DW'(count), 32'd1);
    step("popA5", 1'b0, 1'b0, '0, 1'b1);
    chk("popA5.empty", DW'(empty), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      step("fill", 1'b0, 1'b1, DW'(i), 1'b0);
      if (i == 13) chk("fill13.afull_low", DW'(a_full), 32'd0);
      if (i == 14) chk("fill14.afull_high", DW'(a_full), 32'd1);
      if (i == 15) chk("fill15.full_low", DW'(full), 32'd0);
    end
    chk("fill16.full", DW'(full), 32'd1);
    step("drop17", 1'b0, 1'b1, 32'hFF, 1'b0);
    chk("drop17.cnt", DW'(count), 32'd16);
    chk("drop17.head", read_data, 32'd1);

    step("fullpushpop", 1'b0, 1'b1, 32'h77, 1'b1);
    chk("fullpushpop.cnt", DW'(count), 32'd16);
    chk("fullpushpop.head", read_data, 32'd2);
    for (int i = 2; i <= 16; i++) begin
      chk("drain.order", read_data, DW'(i));
      step("drain", 1'b0, 1'b0, '0, 1'b1);
    end
    chk("drain.last77", read_data, 32'h77);
    step("drain77", 1'b0, 1'b0, '0, 1'b1);
    chk("drain77.empty", DW'(empty), 32'd1);

    for (int i = 0; i < 40; i++) begin
      step("rand", 1'b0, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20; i++) begin
      step("randdrain", 1'b0, 1'b0, '0, 1'b1);
    end

    step("unf_push3C", 1'b0, 1'b1, 32'h3C, 1'b1);
    chk("unf.head3C", read_data, 32'h3C);
    chk("unf.cnt1", DW'(count), 32'd1);
    step("after3C", 1'b0, 1'b0, '0, 1'b0);
    step("pre_rst_a", 1'b0, 1'b1, 32'h11, 1'b0);
    step("pre_rst_b", 1'b0, 1'b1, 32'h22, 1'b0);
    step("midrst", 1'b1, 1'b1, 32'h33, 1'b1);
    chk("midrst.empty", DW'(empty), 32'd1);
    chk("midrst.rdata", read_data, '0);
    chk("midrst.unf", DW'(underflow), 32'd0);
    step("postrst", 1'b0, 1'b1, 32'h44, 1'b0);
    chk("postrst.head", read_data, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
